// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// The helper works on vectors up to 32 requesters wide.
package wrr_arbiter_pkg;

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  localparam int WEIGHT_W = 4;
  localparam int MAX_N    = 32;

  typedef logic [WEIGHT_W-1:0] weight_t;

  // Index of the set bit in a one-hot vector; zero when no bit is set.
  function automatic logic [31:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_arbiter_pick.sv
// Combinational round-robin pick: first request at or above ptr, wrapping to the
// lowest request when nothing at or above ptr is asserted.
module rr_pick
  import wrr_arbiter_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] sel;

  // Isolating the lowest set bit of sel gives the winner without a priority chain.
  always_comb begin
    mask   = ~((N'(1) << ptr) - N'(1));
    masked = req & mask;
    sel    = (masked != '0) ? masked : req;
    onehot = sel & (~sel + N'(1));
    found  = |req;
    idx    = IW'(onehot_to_idx(MAX_N'(onehot)));
  end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with ownership hold: the owner keeps the grant
// until done and may chain up to its weight in transactions before yielding.
module wrr_arbiter
  import wrr_arbiter_pkg::*;
#(
  parameter int N              = 8,
  parameter int WW             = 4,
  parameter int DEFAULT_WEIGHT = 1,
  localparam int IW            = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  input  logic            weight_load,
  input  logic [N*WW-1:0] weights_in,
  output logic [N-1:0]    grants,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [WW-1:0] weight [N];
  logic [WW-1:0] credit [N];

  logic [IW-1:0] owner;
  logic [IW-1:0] owner_next;
  logic [IW-1:0] pick_ptr;
  logic [IW-1:0] pick_idx;
  logic [N-1:0]  pick_onehot;
  logic          pick_found;
  logic          hold;
  logic [WW-1:0] reload_val;

  // On release the scan restarts just past the owner, so it is considered last.
  always_comb begin
    owner      = grant_id;
    owner_next = (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
    reload_val = (weight[owner] == '0) ? WW'(1) : weight[owner];
    hold       = req[owner] && (credit[owner] > WW'(1));
    pick_ptr   = (state == OWNED) ? owner_next : ptr;
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grants   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        weight[i] <= WW'(DEFAULT_WEIGHT);
        credit[i] <= WW'(DEFAULT_WEIGHT);
      end
    end else begin
      // Nonblocking update means a reload on this same edge still sees the old weight.
      if (weight_load) begin
        for (int i = 0; i < N; i++) begin
          weight[i] <= weights_in[i*WW +: WW];
        end
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            grants   <= pick_onehot;
            grant_id <= pick_idx;
            busy     <= 1'b1;
            state    <= OWNED;
          end
        end

        OWNED: begin
          if (done) begin
            if (hold) begin
              credit[owner] <= credit[owner] - WW'(1);
            end else begin
              credit[owner] <= reload_val;
              ptr           <= owner_next;
              grants        <= pick_onehot;
              busy          <= pick_found;
              if (pick_found) begin
                grant_id <= pick_idx;
                state    <= OWNED;
              end else begin
                state    <= IDLE;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed scoreboard bench for wrr_arbiter: stimulus pushes the grant expected after
// each edge and a negedge monitor pops one entry for every cycle the arbiter is busy.
module tb_wrr_arbiter;

  localparam logic [31:0] W_ALL1 = 32'h1111_1111;
  localparam logic [31:0] W_S0_3 = 32'h1111_1113;
  localparam logic [31:0] W_S3_3 = 32'h1111_3111;
  localparam logic [31:0] W_S2_2 = 32'h1111_1211;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] id;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  req;
  logic        done;
  logic        weight_load;
  logic [31:0] weights_in;
  logic [7:0]  grants;
  logic [2:0]  grant_id;
  logic        busy;

  int   checks = 0;
  int   passes = 0;
  exp_t scoreboard [$];

  wrr_arbiter #(
    .N              (8),
    .WW             (4),
    .DEFAULT_WEIGHT (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .weight_load (weight_load),
    .weights_in  (weights_in),
    .grants      (grants),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] idx_of(input logic [7:0] g);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (g[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Drive one cycle of inputs and record the grant expected after the coming edge.
  task automatic applyStimulus(input logic [7:0] r, input logic d, input logic wl,
                               input logic [31:0] w, input logic [7:0] eg);
    exp_t e;
    req         = r;
    done        = d;
    weight_load = wl;
    weights_in  = w;
    if (eg != 8'd0) begin
      e.g  = eg;
      e.id = idx_of(eg);
      scoreboard.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] eg,
                             input logic [2:0] eid, input logic ebusy);
    checks++;
    if (grants === eg && grant_id === eid && busy === ebusy) passes++;
    else $display("[TB] FAIL %s: got grants=%b id=%0d busy=%b, expected grants=%b id=%0d busy=%b",
                  name, grants, grant_id, busy, eg, eid, ebusy);
  endtask

  task automatic checkDrained(input string name);
    @(negedge clk);
    #1;
    checks++;
    if (scoreboard.size() == 0) passes++;
    else begin
      $display("[TB] FAIL %s: got %0d unmatched grants, expected 0", name, scoreboard.size());
      scoreboard.delete();
    end
  endtask

  task automatic doReset();
    rst         = 1'b1;
    req         = '0;
    done        = 1'b0;
    weight_load = 1'b0;
    weights_in  = W_ALL1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (((grants & (grants - 8'd1)) == 8'd0) && (busy == (grants != 8'd0))) passes++;
      else $display("[TB] FAIL invariant: got grants=%b busy=%b, expected one-hot/zero with matching busy",
                    grants, busy);
      if (busy) begin
        checks++;
        if (scoreboard.size() == 0) begin
          $display("[TB] FAIL unexpected_grant: got grants=%b id=%0d, expected idle", grants, grant_id);
        end else begin
          exp_t e;
          e = scoreboard.pop_front();
          if (grants === e.g && grant_id === e.id) passes++;
          else $display("[TB] FAIL grant_seq: got grants=%b id=%0d, expected grants=%b id=%0d",
                        grants, grant_id, e.g, e.id);
        end
      end
    end
  end

  initial begin
    logic [7:0] seq1 [5];
    logic [7:0] seq2 [9];
    logic [7:0] seq6 [6];
    seq1 = '{8'h02, 8'h08, 8'h10, 8'h80, 8'h01};
    seq2 = '{8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02};
    seq6 = '{8'h08, 8'h04, 8'h08, 8'h04, 8'h04, 8'h08};

    rst         = 1'b1;
    req         = '0;
    done        = 1'b0;
    weight_load = 1'b0;
    weights_in  = W_ALL1;
    #1;
    checkOutput("reset_state", 8'h00, 3'd0, 1'b0);
    doReset();

    $display("[TB] round-robin scan with unit weights");
    applyStimulus(8'h9B, 1'b0, 1'b0, W_ALL1, 8'h01);
    foreach (seq1[i]) applyStimulus(8'h9B, 1'b1, 1'b0, W_ALL1, seq1[i]);
    applyStimulus(8'h00, 1'b1, 1'b0, W_ALL1, 8'h00);
    checkDrained("drain_rr");
    checkOutput("idle_after_rr", 8'h00, 3'd0, 1'b0);

    $display("[TB] slot0 weight 3 against slot1");
    doReset();
    applyStimulus(8'h00, 1'b0, 1'b1, W_S0_3, 8'h00);
    applyStimulus(8'h03, 1'b0, 1'b0, W_S0_3, 8'h01);
    foreach (seq2[i]) applyStimulus(8'h03, 1'b1, 1'b0, W_S0_3, seq2[i]);
    applyStimulus(8'h00, 1'b1, 1'b0, W_S0_3, 8'h00);
    checkDrained("drain_weighted");
    checkOutput("idle_after_weighted", 8'h00, 3'd1, 1'b0);

    $display("[TB] ownership hold without req");
    doReset();
    applyStimulus(8'h04, 1'b0, 1'b0, W_ALL1, 8'h04);
    repeat (5) applyStimulus(8'h00, 1'b0, 1'b0, W_ALL1, 8'h04);
    applyStimulus(8'h00, 1'b1, 1'b0, W_ALL1, 8'h00);
    checkDrained("drain_hold");
    checkOutput("release_after_hold", 8'h00, 3'd2, 1'b0);

    $display("[TB] done ignored while idle");
    doReset();
    repeat (3) applyStimulus(8'h00, 1'b1, 1'b0, W_ALL1, 8'h00);
    checkOutput("idle_done", 8'h00, 3'd0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 1'b0, W_ALL1, 8'h01);
    applyStimulus(8'h00, 1'b1, 1'b0, W_ALL1, 8'h00);
    checkDrained("drain_idle_done");

    $display("[TB] reset in the middle of an ownership");
    doReset();
    applyStimulus(8'h00, 1'b0, 1'b1, W_S3_3, 8'h00);
    applyStimulus(8'h08, 1'b0, 1'b0, W_S3_3, 8'h08);
    applyStimulus(8'h08, 1'b1, 1'b0, W_S3_3, 8'h08);
    applyStimulus(8'h08, 1'b1, 1'b0, W_S3_3, 8'h08);
    checkDrained("drain_before_reset");
    rst  = 1'b1;
    done = 1'b0;
    #1;
    checkOutput("async_reset", 8'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(8'hFF, 1'b0, 1'b0, W_ALL1, 8'h01);
    applyStimulus(8'h18, 1'b1, 1'b0, W_ALL1, 8'h08);
    applyStimulus(8'h18, 1'b1, 1'b0, W_ALL1, 8'h10);
    applyStimulus(8'h00, 1'b1, 1'b0, W_ALL1, 8'h00);
    checkDrained("drain_after_reset");

    $display("[TB] weight load coinciding with done");
    doReset();
    applyStimulus(8'h04, 1'b0, 1'b0, W_ALL1, 8'h04);
    applyStimulus(8'h0C, 1'b1, 1'b1, W_S2_2, seq6[0]);
    for (int i = 1; i < 6; i++) applyStimulus(8'h0C, 1'b1, 1'b0, W_S2_2, seq6[i]);
    applyStimulus(8'h00, 1'b1, 1'b0, W_S2_2, 8'h00);
    checkDrained("drain_weight_load");
    checkOutput("idle_after_weight_load", 8'h00, 3'd3, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
